// File: rtl/csr_access_arbiter.sv
// ============================================================================
// csr_access_arbiter
// ----------------------------------------------------------------------------
// Serialises CSR instructions from NUM_REQS requesters onto the single read
// port and single write port of the CSR data store. Each accepted request is
// run as an atomic read-modify-write (CSRRW / CSRRS / CSRRC), and the CSR
// value from before the modification is returned on a response handshake.
//
// Build option:
//   CSR_ARB_RR_EN  defined   -> round-robin arbitration (priority starts at
//                               pointer+1, pointer moves to each winner)
//                  undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_op              per requester: 00 read, 01 RW, 10 RS, 11 RC
//   req_addr/wid/uuid   per requester CSR address, warp id, instruction uuid
//   req_data            per requester operand
//   csr_read_*          CSR store read port (read data is combinational)
//   csr_write_*         CSR store write port
//   rsp_valid/ready     response handshake
//   rsp_idx/uuid/data   requester index, uuid and old CSR value
//   busy                high whenever the FSM is not idle
// ============================================================================
module csr_access_arbiter #(
    parameter int NUM_REQS      = 2,
    parameter int CSR_ADDR_BITS = 12,
    parameter int NW_BITS       = 2,
    parameter int UUID_BITS     = 44,
    localparam int REQ_BITS     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,

    input  logic [NUM_REQS-1:0]             req_valid,
    output logic [NUM_REQS-1:0]             req_ready,
    input  logic [NUM_REQS*2-1:0]           req_op,
    input  logic [NUM_REQS*CSR_ADDR_BITS-1:0] req_addr,
    input  logic [NUM_REQS*NW_BITS-1:0]     req_wid,
    input  logic [NUM_REQS*UUID_BITS-1:0]   req_uuid,
    input  logic [NUM_REQS*32-1:0]          req_data,

    output logic                            csr_read_enable,
    output logic [CSR_ADDR_BITS-1:0]        csr_read_addr,
    output logic [NW_BITS-1:0]              csr_read_wid,
    output logic [UUID_BITS-1:0]            csr_read_uuid,
    input  logic [31:0]                     csr_read_data,

    output logic                            csr_write_enable,
    output logic [CSR_ADDR_BITS-1:0]        csr_write_addr,
    output logic [NW_BITS-1:0]              csr_write_wid,
    output logic [UUID_BITS-1:0]            csr_write_uuid,
    output logic [31:0]                     csr_write_data,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [REQ_BITS-1:0]             rsp_idx,
    output logic [UUID_BITS-1:0]            rsp_uuid,
    output logic [31:0]                     rsp_data,

    output logic                            busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    // ------------------------------------------------------------------
    // Per-requester views of the flattened request buses
    // ------------------------------------------------------------------
    logic [1:0]               w_op   [NUM_REQS];
    logic [CSR_ADDR_BITS-1:0] w_addr [NUM_REQS];
    logic [NW_BITS-1:0]       w_wid  [NUM_REQS];
    logic [UUID_BITS-1:0]     w_uuid [NUM_REQS];
    logic [31:0]              w_data [NUM_REQS];

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
        assign w_op[gi]   = req_op[gi*2 +: 2];
        assign w_addr[gi] = req_addr[gi*CSR_ADDR_BITS +: CSR_ADDR_BITS];
        assign w_wid[gi]  = req_wid[gi*NW_BITS +: NW_BITS];
        assign w_uuid[gi] = req_uuid[gi*UUID_BITS +: UUID_BITS];
        assign w_data[gi] = req_data[gi*32 +: 32];
    end

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    logic [1:0]               r_state;
    logic [1:0]               r_op;
    logic [CSR_ADDR_BITS-1:0] r_addr;
    logic [NW_BITS-1:0]       r_wid;
    logic [UUID_BITS-1:0]     r_uuid;
    logic [31:0]              r_data;
    logic [REQ_BITS-1:0]      r_idx;
    logic [31:0]              r_old;
    logic [31:0]              r_wdata;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                w_grant_found;
    logic [REQ_BITS-1:0] w_grant_idx;

`ifdef CSR_ARB_RR_EN
    logic [REQ_BITS-1:0] r_rr_ptr;

    // Scan starting one past the last winner so every requester is served
    // within NUM_REQS grants under continuous contention.
    always_comb begin
        logic [REQ_BITS-1:0] v_cand;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        v_cand        = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            v_cand = REQ_BITS'((int'(r_rr_ptr) + 1 + k) % NUM_REQS);
            if (!w_grant_found && req_valid[v_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = v_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= REQ_BITS'(NUM_REQS - 1);
        end else if (r_state == S_IDLE && w_grant_found) begin
            r_rr_ptr <= w_grant_idx;
        end
    end
`else
    always_comb begin
        logic [REQ_BITS-1:0] v_cand;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        v_cand        = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            v_cand = REQ_BITS'(k);
            if (!w_grant_found && req_valid[v_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = v_cand;
            end
        end
    end
`endif

    // Reset gates the accept so nothing is handed over during a reset cycle.
    logic w_accept;
    assign w_accept = (r_state == S_IDLE) && w_grant_found && !reset;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
        assign req_ready[gi] = w_accept && (w_grant_idx == REQ_BITS'(gi));
    end

    // ------------------------------------------------------------------
    // Modify step, evaluated while the read port is active
    // ------------------------------------------------------------------
    logic [31:0] w_new;
    logic        w_need_write;

    always_comb begin
        w_new = csr_read_data;
        case (r_op)
            OP_RW:   w_new = r_data;
            OP_RS:   w_new = csr_read_data | r_data;
            OP_RC:   w_new = csr_read_data & ~r_data;
            default: w_new = csr_read_data;
        endcase
    end

    // Set/clear with a zero mask leaves the CSR untouched, so skip the write.
    assign w_need_write = (r_op == OP_RW) || (r_op[1] && (r_data != 32'd0));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_wid   <= '0;
            r_uuid  <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_old   <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        r_op    <= w_op[w_grant_idx];
                        r_addr  <= w_addr[w_grant_idx];
                        r_wid   <= w_wid[w_grant_idx];
                        r_uuid  <= w_uuid[w_grant_idx];
                        r_data  <= w_data[w_grant_idx];
                        r_idx   <= w_grant_idx;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_old   <= csr_read_data;
                    r_wdata <= w_new;
                    r_state <= w_need_write ? S_WRITE : S_RESP;
                end
                S_WRITE: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign csr_read_enable  = (r_state == S_READ);
    assign csr_read_addr    = r_addr;
    assign csr_read_wid     = r_wid;
    assign csr_read_uuid    = r_uuid;

    // A reset landing in WRITE must not let the store commit the value.
    assign csr_write_enable = (r_state == S_WRITE) && !reset;
    assign csr_write_addr   = r_addr;
    assign csr_write_wid    = r_wid;
    assign csr_write_uuid   = r_uuid;
    assign csr_write_data   = r_wdata;

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_idx   = r_idx;
    assign rsp_uuid  = r_uuid;
    assign rsp_data  = r_old;

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_csr_access_arbiter.sv
module tb_csr_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [23:0] req_addr;
    logic [3:0]  req_wid;
    logic [87:0] req_uuid;
    logic [63:0] req_data;
    logic        csr_read_enable;
    logic [11:0] csr_read_addr;
    logic [1:0]  csr_read_wid;
    logic [43:0] csr_read_uuid;
    logic [31:0] csr_read_data;
    logic        csr_write_enable;
    logic [11:0] csr_write_addr;
    logic [1:0]  csr_write_wid;
    logic [43:0] csr_write_uuid;
    logic [31:0] csr_write_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_idx;
    logic [43:0] rsp_uuid;
    logic [31:0] rsp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    csr_access_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_wid          (req_wid),
        .req_uuid         (req_uuid),
        .req_data         (req_data),
        .csr_read_enable  (csr_read_enable),
        .csr_read_addr    (csr_read_addr),
        .csr_read_wid     (csr_read_wid),
        .csr_read_uuid    (csr_read_uuid),
        .csr_read_data    (csr_read_data),
        .csr_write_enable (csr_write_enable),
        .csr_write_addr   (csr_write_addr),
        .csr_write_wid    (csr_write_wid),
        .csr_write_uuid   (csr_write_uuid),
        .csr_write_data   (csr_write_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_idx          (rsp_idx),
        .rsp_uuid         (rsp_uuid),
        .rsp_data         (rsp_data),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Behavioural CSR store: combinational read, write on the clock edge.
    logic [31:0] mem [0:4095];
    assign csr_read_data = mem[csr_read_addr];
    always @(posedge clk) begin
        if (csr_write_enable) mem[csr_write_addr] <= csr_write_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [11:0] addr,
                           input logic [1:0] wid, input logic [43:0] uuid, input logic [31:0] data);
        req_op[i*2 +: 2]     = op;
        req_addr[i*12 +: 12] = addr;
        req_wid[i*2 +: 2]    = wid;
        req_uuid[i*44 +: 44] = uuid;
        req_data[i*32 +: 32] = data;
    endtask

    int  n;
    bit  found;
    logic [1:0] exp_grant [4];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        mem[12'h300] = 32'h1;
        mem[12'h301] = 32'h55;
        mem[12'h302] = 32'hFF;

        reset = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_wid = '0;
        req_uuid = '0; req_data = '0; rsp_ready = 1'b1;

        // ---------------- reset state ----------------
        step(); step();
        req_valid = 2'b11; #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rd_en", csr_read_enable, 0);
        chk("rst_wr_en", csr_write_enable, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_uuid", rsp_uuid, 0);
        chk("rst_rsp_idx", rsp_idx, 0);
        req_valid = 2'b00;
        reset = 1'b0;
        step();
        $display("reset done");

        // ---------------- single RW on req0 ----------------
        set_req(0, 2'b01, 12'h300, 2'd1, 44'h123, 32'h8);
        req_valid = 2'b01; #1;
        chk("rw_ready_T", req_ready, 2'b01);
        step(); req_valid = 2'b00; #1;                       // T+1
        chk("rw_rd_en", csr_read_enable, 1);
        chk("rw_rd_addr", csr_read_addr, 12'h300);
        chk("rw_rd_uuid", csr_read_uuid, 44'h123);
        chk("rw_rd_wid", csr_read_wid, 1);
        chk("rw_wr_en_T1", csr_write_enable, 0);
        chk("rw_busy", busy, 1);
        step();                                               // T+2
        chk("rw_wr_en", csr_write_enable, 1);
        chk("rw_wr_data", csr_write_data, 32'h8);
        chk("rw_wr_addr", csr_write_addr, 12'h300);
        chk("rw_rd_en_T2", csr_read_enable, 0);
        chk("rw_rsp_T2", rsp_valid, 0);
        step();                                               // T+3
        chk("rw_rsp_valid", rsp_valid, 1);
        chk("rw_rsp_data", rsp_data, 32'h1);
        chk("rw_rsp_idx", rsp_idx, 0);
        chk("rw_rsp_uuid", rsp_uuid, 44'h123);
        chk("rw_wr_en_T3", csr_write_enable, 0);
        step();
        chk("rw_idle", busy, 0);
        chk("rw_mem", mem[12'h300], 32'h8);
        $display("txn RW req0 addr=300 old=%0h", rsp_data);

        // ---------------- RS with zero mask on req1 ----------------
        set_req(1, 2'b10, 12'h301, 2'd2, 44'h222, 32'h0);
        req_valid = 2'b10; #1;
        chk("rs0_ready", req_ready, 2'b10);
        step(); req_valid = 2'b00; #1;                       // T+1
        chk("rs0_rd_en", csr_read_enable, 1);
        chk("rs0_wr_en_T1", csr_write_enable, 0);
        step();                                               // T+2
        chk("rs0_rsp_valid", rsp_valid, 1);
        chk("rs0_wr_en_T2", csr_write_enable, 0);
        chk("rs0_rsp_data", rsp_data, 32'h55);
        chk("rs0_rsp_idx", rsp_idx, 1);
        chk("rs0_rsp_uuid", rsp_uuid, 44'h222);
        step();
        chk("rs0_idle", busy, 0);
        chk("rs0_mem", mem[12'h301], 32'h55);
        $display("txn RS0 req1 addr=301");

        // ---------------- RC on req0 ----------------
        set_req(0, 2'b11, 12'h302, 2'd0, 44'h333, 32'h0F);
        req_valid = 2'b01; #1;
        chk("rc_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        step();                                               // T+2
        chk("rc_wr_en", csr_write_enable, 1);
        chk("rc_wr_data", csr_write_data, 32'hF0);
        step();                                               // T+3
        chk("rc_rsp_data", rsp_data, 32'hFF);
        step();
        chk("rc_mem", mem[12'h302], 32'hF0);
        $display("txn RC req0 addr=302");

        // ---------------- backpressure ----------------
        rsp_ready = 1'b0;
        set_req(1, 2'b01, 12'h300, 2'd3, 44'h444, 32'h77);
        req_valid = 2'b10; #1;
        chk("bp_ready", req_ready, 2'b10);
        step(); req_valid = 2'b11;                            // T+1, both pending
        step();                                               // T+2
        step();                                               // T+3
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 32'h8);
            chk("bp_rsp_idx", rsp_idx, 1);
            chk("bp_rsp_uuid", rsp_uuid, 44'h444);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
            step();
        end
        rsp_ready = 1'b1; req_valid = 2'b00;
        step();
        chk("bp_idle", busy, 0);
        chk("bp_rsp_drop", rsp_valid, 0);
        $display("txn BP req1 addr=300 held 5 cycles");

        // ---------------- contention ----------------
`ifdef CSR_ARB_RR_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
`endif
        set_req(0, 2'b00, 12'h300, 2'd0, 44'h500, 32'h0);
        set_req(1, 2'b00, 12'h300, 2'd1, 44'h501, 32'h0);
        req_valid = 2'b11;
        n = 0;
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            while (!found && n < 10) begin
                #1;
                if (req_ready != 2'b00) found = 1'b1;
                else begin
                    step();
                    n++;
                end
            end
            chk("cont_grant", req_ready, exp_grant[g]);
            if (g > 0) chk("cont_gap", n, 3);
            $display("txn contention grant %0d ready=%b", g, req_ready);
            step();
            n = 1;
        end
        req_valid = 2'b00;
        n = 0;
        while (busy && n < 10) begin
            step();
            n++;
        end
        chk("cont_drain", busy, 0);

        // ---------------- reset during WRITE ----------------
        set_req(0, 2'b01, 12'h301, 2'd1, 44'h666, 32'hAA);
        req_valid = 2'b01; #1;
        chk("rstw_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;                            // READ
        step();                                               // WRITE
        chk("rstw_wr_en", csr_write_enable, 1);
        reset = 1'b1;
        step();
        chk("rstw_busy", busy, 0);
        chk("rstw_rsp_valid", rsp_valid, 0);
        chk("rstw_wr_en_after", csr_write_enable, 0);
        chk("rstw_rd_en", csr_read_enable, 0);
        chk("rstw_rsp_data", rsp_data, 0);
        chk("rstw_rsp_uuid", rsp_uuid, 0);
        chk("rstw_rsp_idx", rsp_idx, 0);
        chk("rstw_ready_after", req_ready, 0);
        reset = 1'b0;
        step();
        chk("rstw_no_rsp", rsp_valid, 0);
        chk("rstw_idle", busy, 0);
        chk("rstw_mem", mem[12'h301], 32'h55);
        $display("txn reset-in-WRITE addr=301");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
